// File: rtl/uart_ctrl_pkg.sv
// Shared constants and FSM state encoding for the UART transmit scheduler.
package uart_ctrl_pkg;

    localparam int N_REQ_DEF        = 4;
    localparam int BUSY_TIMEOUT_DEF = 15;
    localparam int BYTE_W           = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping around.
module rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] pos;

    // Walk offsets 1..N_REQ so the pointer's own slot is considered last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one async_transmitter between N_REQ byte producers using round-robin
// arbitration over one-byte holding registers, with start-pulse retry on timeout.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic [ID_W-1:0]         grant_id,
    output logic                    active,
    output logic [7:0]              retry_cnt
);

    localparam int              CNT_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_START     = START;
    localparam logic [1:0] S_WAIT_BUSY = WAIT_BUSY;
    localparam logic [1:0] S_WAIT_DONE = WAIT_DONE;

    logic [1:0]        state;
    logic [N_REQ-1:0]  hold_full;
    logic [N_REQ-1:0]  hold_full_nxt;
    logic [N_REQ-1:0]  accept;
    logic [N_REQ-1:0]  done_clr;
    logic [BYTE_W-1:0] hold_data [N_REQ];
    logic [ID_W-1:0]   last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic              frame_done;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (hold_full),
        .ptr   (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign accept     = req_valid & req_ready;
    assign frame_done = (state == S_WAIT_DONE) && !tx_busy;
    assign tx_start   = (state == S_START);
    assign active     = (state != S_IDLE);

    always_comb begin
        done_clr = '0;
        if (frame_done) done_clr[grant_id] = 1'b1;
    end

    assign hold_full_nxt = (hold_full | accept) & ~done_clr;

    // req_ready mirrors the next fill state so a slot never accepts twice before it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full <= '0;
            req_ready <= '0;
        end else begin
            hold_full <= hold_full_nxt;
            req_ready <= ~hold_full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) hold_data[i] <= req_data[BYTE_W*i +: BYTE_W];
        end
    end

    // A start pulse that the transmitter never acknowledges is repeated after BUSY_TIMEOUT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            wait_cnt   <= '0;
            retry_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found && !tx_busy) begin
                        grant_id <= pick_idx;
                        tx_data  <= hold_data[pick_idx];
                        state    <= S_START;
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        state <= S_START;
                        if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        last_grant <= grant_id;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        active;
    logic [7:0]  retry_cnt;

    int total = 0;
    int bad   = 0;

    uart_tx_scheduler #(
        .N_REQ        (N),
        .ID_W         (2),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  ready;
        logic        start;
        logic        act;
        logic        chk;
        logic [7:0]  txd;
        logic [1:0]  gid;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic b);
        req_valid = v;
        req_data  = d;
        tx_busy   = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(4'h0, 32'h0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_start", 32'(tx_start), 32'h0);
        checkOutput("rst_txdata", 32'(tx_data), 32'h0);
        checkOutput("rst_grant", 32'(grant_id), 32'h0);
        checkOutput("rst_active", 32'(active), 32'h0);
        checkOutput("rst_retry", 32'(retry_cnt), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("ready_after_rst", 32'(req_ready), 32'hF);
    endtask

    task automatic waitStart(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < 60);
        checkOutput("start_seen", 32'(tx_start), 32'h1);
    endtask

    function automatic int rrPick(input bit [3:0] f, input int last);
        for (int k = 1; k <= N; k++) begin
            if (f[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[$];
        int n;
        bit [3:0] mfull, prevFull, expReady, drvValid;
        logic [7:0] mdata [N];
        logic [31:0] drvData;
        bit drvBusy, inFrame, busyHigh;
        int mlast, fGrant, busyLeft, accepted, sent, exp;
        logic [7:0] fData, expByte;

        // Single byte on requester 2, then a byte offered while the transmitter is busy.
        vecs.push_back('{4'b0100, 32'h00A5_0000, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd2});
        vecs.push_back('{4'b0000, 32'h0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd2});
        vecs.push_back('{4'b0000, 32'h0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd2});
        vecs.push_back('{4'b0000, 32'h0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd2});
        vecs.push_back('{4'b0000, 32'h0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        vecs.push_back('{4'b0001, 32'h0000_003C, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b1, 8'h3C, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b1, 4'b1110, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd0});
        vecs.push_back('{4'b0000, 32'h0, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});

        resetDut();
        foreach (vecs[r]) begin
            applyStimulus(vecs[r].valid, vecs[r].data, vecs[r].busy);
            tick();
            checkOutput($sformatf("vec%0d_ready", r), 32'(req_ready), 32'(vecs[r].ready));
            checkOutput($sformatf("vec%0d_start", r), 32'(tx_start), 32'(vecs[r].start));
            checkOutput($sformatf("vec%0d_active", r), 32'(active), 32'(vecs[r].act));
            if (vecs[r].chk) begin
                checkOutput($sformatf("vec%0d_txdata", r), 32'(tx_data), 32'(vecs[r].txd));
                checkOutput($sformatf("vec%0d_grant", r), 32'(grant_id), 32'(vecs[r].gid));
            end
        end

        // Fairness: all four load together and keep refilling; two full rounds in order.
        resetDut();
        applyStimulus(4'hF, 32'h1312_1110, 1'b0);
        tick();
        req_data = 32'h2322_2120;
        for (int f = 0; f < 8; f++) begin
            waitStart(n);
            checkOutput($sformatf("fair%0d_gap", f), 32'(n), (f == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("fair%0d_grant", f), 32'(grant_id), 32'(f % 4));
            expByte = (f < 4) ? 8'(8'h10 + f) : 8'(8'h20 + f - 4);
            checkOutput($sformatf("fair%0d_data", f), 32'(tx_data), 32'(expByte));
            if (f >= 4) req_valid[f % 4] = 1'b0;
            tx_busy = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                checkOutput("fair_stable_data", 32'(tx_data), 32'(expByte));
                checkOutput("fair_stable_grant", 32'(grant_id), 32'(f % 4));
                checkOutput("fair_active", 32'(active), 32'h1);
            end
            tx_busy = 1'b0;
        end
        tick();
        tick();
        checkOutput("fair_drained_active", 32'(active), 32'h0);
        checkOutput("fair_drained_ready", 32'(req_ready), 32'hF);

        // Timeout retry: transmitter never acknowledges the first start pulse.
        resetDut();
        applyStimulus(4'b0010, 32'h0000_5A00, 1'b0);
        tick();
        req_valid = 4'h0;
        waitStart(n);
        checkOutput("retry_latency", 32'(n), 32'd1);
        checkOutput("retry_first_cnt", 32'(retry_cnt), 32'd0);
        waitStart(n);
        checkOutput("retry_gap", 32'(n), 32'(TO + 1));
        checkOutput("retry_data", 32'(tx_data), 32'h5A);
        checkOutput("retry_grant", 32'(grant_id), 32'd1);
        checkOutput("retry_cnt", 32'(retry_cnt), 32'd1);
        tx_busy = 1'b1;
        tick();
        tick();
        tx_busy = 1'b0;
        tick();
        checkOutput("retry_done_active", 32'(active), 32'h0);
        checkOutput("retry_done_ready", 32'(req_ready), 32'hF);

        // Reset while a frame is in WAIT_DONE with two more bytes held.
        resetDut();
        applyStimulus(4'b0001, 32'h0000_0077, 1'b0);
        tick();
        req_valid = 4'h0;
        waitStart(n);
        tx_busy = 1'b1;
        tick();
        tick();
        applyStimulus(4'b1100, 32'hBBAA_0000, 1'b1);
        tick();
        req_valid = 4'h0;
        checkOutput("midrst_held_ready", 32'(req_ready), 32'h2);
        checkOutput("midrst_active", 32'(active), 32'h1);
        rst = 1'b1;
        tick();
        checkOutput("midrst_ready", 32'(req_ready), 32'h0);
        checkOutput("midrst_start", 32'(tx_start), 32'h0);
        checkOutput("midrst_txdata", 32'(tx_data), 32'h0);
        checkOutput("midrst_grant", 32'(grant_id), 32'h0);
        checkOutput("midrst_act", 32'(active), 32'h0);
        checkOutput("midrst_retry", 32'(retry_cnt), 32'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c == 6) tx_busy = 1'b0;
            tick();
            checkOutput("midrst_no_start", 32'(tx_start), 32'h0);
            checkOutput("midrst_idle", 32'(active), 32'h0);
        end
        checkOutput("midrst_ready_after", 32'(req_ready), 32'hF);

        // Randomized traffic against a round-robin transaction model.
        resetDut();
        mfull = '0;
        mlast = N - 1;
        inFrame = 1'b0;
        busyHigh = 1'b0;
        busyLeft = 0;
        accepted = 0;
        sent = 0;
        fGrant = 0;
        fData = '0;
        for (int i = 0; i < 1200; i++) begin
            if (i >= 600 && mfull == 0 && !inFrame) break;
            drvValid = (i < 600) ? 4'($urandom_range(0, 15)) : 4'h0;
            drvData  = $urandom;
            drvBusy  = (busyLeft > 0);
            applyStimulus(drvValid, drvData, drvBusy);
            tick();
            prevFull = mfull;
            if (inFrame && busyHigh && !drvBusy) begin
                mfull[fGrant] = 1'b0;
                mlast = fGrant;
                inFrame = 1'b0;
                busyHigh = 1'b0;
            end
            for (int r = 0; r < N; r++) begin
                if (drvValid[r] && !prevFull[r]) begin
                    mfull[r] = 1'b1;
                    mdata[r] = drvData[8*r +: 8];
                    accepted++;
                end
            end
            if (drvBusy && inFrame) busyHigh = 1'b1;
            if (busyLeft > 0) busyLeft--;
            if (tx_start) begin
                checkOutput("rand_no_restart", 32'(inFrame), 32'h0);
                exp = rrPick(prevFull, mlast);
                checkOutput("rand_winner_exists", (exp >= 0) ? 32'h1 : 32'h0, 32'h1);
                if (exp < 0) exp = 0;
                checkOutput("rand_grant", 32'(grant_id), 32'(exp));
                checkOutput("rand_data", 32'(tx_data), 32'(mdata[exp]));
                inFrame = 1'b1;
                busyHigh = 1'b0;
                fGrant = exp;
                fData = mdata[exp];
                busyLeft = $urandom_range(2, 6);
                sent++;
            end
            expReady = ~mfull;
            checkOutput("rand_ready", 32'(req_ready), 32'(expReady));
            checkOutput("rand_active", 32'(active), 32'(inFrame));
            if (inFrame) begin
                checkOutput("rand_stable_data", 32'(tx_data), 32'(fData));
                checkOutput("rand_stable_grant", 32'(grant_id), 32'(fGrant));
            end
        end
        checkOutput("rand_all_sent", 32'(sent), 32'(accepted));
        checkOutput("rand_drained", 32'(mfull), 32'h0);
        checkOutput("rand_no_retry", 32'(retry_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
